// File: rtl/uart_transmit_fifo.sv
// UART transmitter fed by a small word FIFO: configurable data width, parity and stop bits.
// Frames are sent LSB first and back-to-back while the FIFO holds words.
module uart_transmit_fifo #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out,
  output logic                          busy_out,
  output logic                          frame_done_out,
  output logic                          tx_wire_out
);

  localparam int PERIOD_CYCLES = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(PERIOD_CYCLES);

  localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [3:0]    DATA_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST   = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Odd parity makes the total count of ones odd, even parity makes it even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    logic p;
    p = ^word;
    if (PARITY == 1) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 push_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic                 last_stop_s;
  logic [DATA_BITS-1:0] head_word_s;

  // Serialiser next-state: bit timing, shifting, and popping the head word into the shifter.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = tx_q;
    head_word_s = mem_q[rd_ptr_q];
    bit_end_s   = (timer_q == {TW{1'b0}});
    last_stop_s = (state_q == ST_STOP) && bit_end_s && (bit_q == STOP_LAST);
    pop_s       = (count_q != {CW{1'b0}}) && ((state_q == ST_IDLE) || last_stop_s);

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_START;
          timer_d = PERIOD_LAST;
          bit_d   = 4'd0;
          shift_d = head_word_s;
          par_d   = parity_bit(head_word_s);
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          timer_d = PERIOD_LAST;
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          timer_d = PERIOD_LAST;
          if (bit_q == DATA_LAST) begin
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              bit_d   = 4'd0;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
          timer_d = PERIOD_LAST;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_STOP: begin
        if (last_stop_s) begin
          // A queued word starts its start bit with no idle gap.
          if (pop_s) begin
            state_d = ST_START;
            timer_d = PERIOD_LAST;
            bit_d   = 4'd0;
            shift_d = head_word_s;
            par_d   = parity_bit(head_word_s);
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else if (bit_end_s) begin
          timer_d = PERIOD_LAST;
          bit_d   = bit_q + 4'd1;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointers, occupancy and the registered status flags.
  always_comb begin
    push_s   = valid_in && ready_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    ready_d = (count_d != DEPTH_C);
    busy_d  = (state_d != ST_IDLE) || (count_d != {CW{1'b0}});
    done_d  = (state_d == ST_STOP) && (bit_d == STOP_LAST) && (timer_d == {TW{1'b0}});
  end

  // State and status registers; reset discards the queue and any frame in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      timer_q  <= {TW{1'b0}};
      bit_q    <= 4'd0;
      shift_q  <= {DATA_BITS{1'b0}};
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      count_q  <= {CW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Word storage; stale entries are harmless because the pointers gate every read.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ready_out      = ready_q;
  assign count_out      = count_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign tx_wire_out    = tx_q;

endmodule
